jk_ff_sequencer: RTL and testbench
==================================

JK_FF_SEQUENCER -- requirements
Module: jk_ff_sequencer

Role: upstream driver/checker for the team's single-bit JK flip-flop. It accepts JK commands over a valid/ready handshake, drives J/K/flop-reset for one clock, samples Q/Qbar, compares them against an internal reference model and reports pass/fail.

Interface
REQ-001 Parameter ERR_W, default 8, width of the saturating error counter.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous reset, active-high; sampled on the rising edge of clk.
REQ-004 cmd_valid  input  1  command present.
REQ-005 cmd_jk  input  2  {J,K} to apply: 00 hold, 01 reset Q, 10 set Q, 11 toggle.
REQ-006 cmd_clr  input  1  when 1, the command is a flop clear; cmd_jk is ignored.
REQ-007 cmd_ready  output  1  sequencer can accept a command.
REQ-008 J, K  output  1 each  registered drive to the flip-flop J/K inputs.
REQ-009 ff_rst  output  1  registered drive to the flip-flop rst input.
REQ-010 q_in, qbar_in  input  1 each  flip-flop Q and Qbar.
REQ-011 rsp_valid  output  1  one-cycle result strobe.
REQ-012 rsp_pass  output  1  result; meaningful only while rsp_valid=1.
REQ-013 exp_q  output  1  current reference-model Q.
REQ-014 err_cnt  output  ERR_W  count of failed checks.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, DRIVE, CHECK and RESP.
REQ-016 cmd_ready SHALL be 1 only in IDLE and SHALL be combinational from state.
REQ-017 Accept: a command is accepted on a rising edge where cmd_valid=1 and cmd_ready=1; cmd_jk and cmd_clr are latched, and IDLE goes to DRIVE.
REQ-018 DRIVE (1 cycle): J/K SHALL equal the latched cmd_jk, or 00 if the command is a clear; ff_rst SHALL equal the latched cmd_clr; next state is CHECK.
REQ-019 Outside DRIVE, J, K and ff_rst SHALL all be 0.
REQ-020 On accept, the model SHALL compute exp_next:
- 0 if cmd_clr=1;
- otherwise (J & ~exp_q) | (~K & exp_q).
REQ-021 CHECK (1 cycle): on the edge leaving CHECK, pass is determined as (q_in == exp_next) && (qbar_in == ~q_in); next state is RESP.
REQ-022 RESP (1 cycle): rsp_valid=1 and rsp_pass holds the CHECK result; next state is IDLE.
REQ-023 Latency and throughput:
- accept edge to rsp_valid high is 3 cycles;
- one command per 4 cycles maximum.
REQ-024 On pass, exp_q SHALL update to exp_next at the edge leaving CHECK.
REQ-025 On fail, exp_q SHALL resynchronise to the sampled q_in (no cascading errors), and err_cnt SHALL increment.
REQ-026 err_cnt SHALL saturate at 2^ERR_W-1 and never wrap.
REQ-027 A Q/Qbar non-complement SHALL count as a fail even when q_in == exp_next.
REQ-028 cmd_valid with cmd_ready=0 SHALL be ignored with no side effects; the source must hold the command until it is accepted.
REQ-029 Inputs cmd_jk and cmd_clr SHALL be ignored except on the accept edge.

Reset
REQ-030 With rst=1 at a rising edge, the next state SHALL be:
- state=IDLE;
- J=K=0, ff_rst=0;
- rsp_valid=0, rsp_pass=0;
- exp_q=0, err_cnt=0.
REQ-031 rst SHALL override every state, including mid-command (DRIVE/CHECK/RESP): the in-flight command is discarded and no rsp_valid is produced.
REQ-032 rst and cmd_valid asserted on the same edge: reset wins and the command is not accepted.
REQ-033 The integrator SHALL drive the flip-flop rst from (rst | ff_rst) so that flop Q=0 matches exp_q=0 after reset.

Verification
REQ-034 Reset, then cmd_jk=10 -> J=1,K=0 in DRIVE; rsp_valid 3 cycles after accept; rsp_pass=1; exp_q=1.
REQ-035 Sequence 10, 11, 11, 01, 00 on a correct flop -> exp_q goes 1,0,1,0,0; all pass; err_cnt=0.
REQ-036 Flop forced Q stuck-at-0, then cmd 10 -> rsp_pass=0, err_cnt=1, exp_q=0; a following cmd 00 -> pass.
REQ-037 With exp_q=1, cmd_clr=1 -> ff_rst=1 for exactly the DRIVE cycle with J=K=0; pass; exp_q=0.
REQ-038 rst asserted in CHECK -> no rsp_valid, IDLE next cycle, cmd_ready=1; cmd_valid held during DRIVE/CHECK/RESP is not accepted early.
REQ-039 ERR_W=2 with 5 forced fails -> err_cnt stays at 3.

Source files
------------

// File: rtl/jk_ff_sequencer.sv
// Upstream driver/checker for a single-bit JK flip-flop: accepts a command, drives J/K/ff_rst
// for one cycle, samples Q/Qbar and compares them against an internal reference model.
module jk_ff_sequencer #(
   parameter int ERR_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   input  logic [1:0]       cmd_jk,
   input  logic             cmd_clr,
   output logic             cmd_ready,
   output logic             J,
   output logic             K,
   output logic             ff_rst,
   input  logic             q_in,
   input  logic             qbar_in,
   output logic             rsp_valid,
   output logic             rsp_pass,
   output logic             exp_q,
   output logic [ERR_W-1:0] err_cnt
);

   typedef enum logic [1:0] {IDLE, DRIVE, CHECK, RESP} state_t;

   state_t state, state_nxt;
   logic   exp_next;
   logic   accept;
   logic   check_pass;
   logic   model_next;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:  if (cmd_valid) state_nxt = DRIVE;
         DRIVE: state_nxt = CHECK;
         CHECK: state_nxt = RESP;
         RESP:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign cmd_ready  = (state == IDLE);
   assign accept     = cmd_valid && cmd_ready;
   assign model_next = cmd_clr ? 1'b0 : ((cmd_jk[1] & ~exp_q) | (~cmd_jk[0] & exp_q));
   // A Q/Qbar pair that is not complementary fails even if Q itself matches.
   assign check_pass = (q_in == exp_next) && (qbar_in == ~q_in);

   // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         J         <= 1'b0;
         K         <= 1'b0;
         ff_rst    <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_pass  <= 1'b0;
         exp_q     <= 1'b0;
         exp_next  <= 1'b0;
         err_cnt   <= '0;
      end else begin
         state     <= state_nxt;
         J         <= 1'b0;
         K         <= 1'b0;
         ff_rst    <= 1'b0;
         rsp_valid <= 1'b0;
         // J/K/ff_rst are loaded on the accept edge so they are live exactly during DRIVE.
         if (accept) begin
            J        <= cmd_jk[1] & ~cmd_clr;
            K        <= cmd_jk[0] & ~cmd_clr;
            ff_rst   <= cmd_clr;
            exp_next <= model_next;
         end
         if (state == CHECK) begin
            rsp_valid <= 1'b1;
            rsp_pass  <= check_pass;
            if (check_pass) begin
               exp_q <= exp_next;
            end else begin
               // Resynchronise to the observed flop so one fault does not cascade.
               exp_q <= q_in;
               if (err_cnt != {ERR_W{1'b1}}) err_cnt <= err_cnt + ERR_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_jk_ff_sequencer.sv
// Scoreboard bench for jk_ff_sequencer: driver pushes hand-computed results, a monitor
// pops and compares on every rsp_valid strobe. A behavioural JK flop with fault hooks closes the loop.
module tb_jk_ff_sequencer;

   localparam int ERR_W = 2;

   typedef struct {
      logic             pass;
      logic             q;
      logic [ERR_W-1:0] err;
      int               acc_cyc;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             cmd_valid = 1'b0;
   logic [1:0]       cmd_jk = 2'b00;
   logic             cmd_clr = 1'b0;
   logic             cmd_ready, J, K, ff_rst;
   logic             q_in, qbar_in;
   logic             rsp_valid, rsp_pass, exp_q;
   logic [ERR_W-1:0] err_cnt;

   logic ff_q = 1'b0;
   logic stuck0 = 1'b0;
   logic noncomp = 1'b0;

   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   exp_t sb[$];

   jk_ff_sequencer #(.ERR_W(ERR_W)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_jk(cmd_jk), .cmd_clr(cmd_clr),
      .cmd_ready(cmd_ready), .J(J), .K(K), .ff_rst(ff_rst), .q_in(q_in), .qbar_in(qbar_in),
      .rsp_valid(rsp_valid), .rsp_pass(rsp_pass), .exp_q(exp_q), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Flop under test, reset from rst | ff_rst; stuck0 forces its stored value to 0.
   always @(posedge clk) begin
      if (rst || ff_rst || stuck0) ff_q <= 1'b0;
      else begin
         case ({J, K})
            2'b01:   ff_q <= 1'b0;
            2'b10:   ff_q <= 1'b1;
            2'b11:   ff_q <= ~ff_q;
            default: ff_q <= ff_q;
         endcase
      end
   end
   assign q_in    = ff_q;
   assign qbar_in = noncomp ? ff_q : ~ff_q;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: every rsp_valid strobe must match the oldest expectation.
   always @(negedge clk) begin
      if (!rst && rsp_valid) begin
         if (sb.size() == 0) begin
            check("unexpected_rsp_valid", 32'(rsp_valid), 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("rsp_pass", 32'(rsp_pass), 32'(e.pass));
            check("exp_q", 32'(exp_q), 32'(e.q));
            check("err_cnt", 32'(err_cnt), 32'(e.err));
            check("latency", 32'(cyc - e.acc_cyc), 32'd3);
         end
      end
   end

   // Called on a negedge; returns on the negedge of the IDLE cycle after RESP.
   task automatic issue(input logic [1:0] jk, input logic clr, input logic f_stuck,
                        input logic f_noncomp, input logic e_pass, input logic e_q,
                        input logic [ERR_W-1:0] e_err);
      exp_t e;
      int   n = 0;
      while (!cmd_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) begin
         check("ready_timeout", 32'(cmd_ready), 32'd1);
         return;
      end
      stuck0    = f_stuck;
      noncomp   = f_noncomp;
      cmd_valid = 1'b1;
      cmd_jk    = jk;
      cmd_clr   = clr;
      e.pass = e_pass;
      e.q    = e_q;
      e.err  = e_err;
      e.acc_cyc = cyc;
      sb.push_back(e);
      @(negedge clk);  // DRIVE
      check("drive_J", 32'(J), 32'(jk[1] & ~clr));
      check("drive_K", 32'(K), 32'(jk[0] & ~clr));
      check("drive_ff_rst", 32'(ff_rst), 32'(clr));
      check("drive_ready", 32'(cmd_ready), 32'd0);
      // Keep valid high with altered fields: must be neither accepted nor sampled.
      cmd_jk  = ~jk;
      cmd_clr = ~clr;
      @(negedge clk);  // CHECK
      check("check_JK_rst", 32'({J, K, ff_rst}), 32'd0);
      @(negedge clk);  // RESP
      check("resp_JK_rst", 32'({J, K, ff_rst}), 32'd0);
      @(negedge clk);  // IDLE
      cmd_valid = 1'b0;
      stuck0    = 1'b0;
      noncomp   = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ready", 32'(cmd_ready), 32'd1);
      check("rst_JK_rst", 32'({J, K, ff_rst}), 32'd0);
      check("rst_rsp", 32'({rsp_valid, rsp_pass}), 32'd0);
      check("rst_exp_q", 32'(exp_q), 32'd0);
      check("rst_err", 32'(err_cnt), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Correct flop: 10,11,11,01,00 -> 1,0,1,0,0
      issue(2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
      issue(2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
      issue(2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
      issue(2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
      issue(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
      // Clear from exp_q=1 (cmd_jk=11 must be ignored)
      issue(2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
      issue(2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
      // Stuck-at-0 then recovery
      issue(2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
      issue(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1);
      // Q matches but Qbar is not its complement
      issue(2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2);

      // Reset during CHECK with cmd_valid held through the reset edges
      cmd_valid = 1'b1;
      cmd_jk    = 2'b10;
      cmd_clr   = 1'b0;
      @(negedge clk);  // DRIVE
      @(negedge clk);  // CHECK
      rst = 1'b1;
      @(negedge clk);
      check("midrst_ready", 32'(cmd_ready), 32'd1);
      check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("midrst_exp_q", 32'(exp_q), 32'd0);
      check("midrst_err", 32'(err_cnt), 32'd0);
      @(negedge clk);
      check("rst_beats_valid_ready", 32'(cmd_ready), 32'd1);
      check("rst_beats_valid_J", 32'(J), 32'd0);
      cmd_valid = 1'b0;
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check("midrst_no_rsp", 32'(rsp_valid), 32'd0);

      // Saturation with ERR_W=2: five fails -> 1,2,3,3,3
      issue(2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
      issue(2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2);
      issue(2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3);
      issue(2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3);
      issue(2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3);
      issue(2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3);

      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
